// File: rtl/bus_fifo_buffer.sv
// bus_fifo_buffer: DEPTH-entry nibble FIFO that drives its oldest entry onto a
// shared tri-state bus while enabled. It reports occupancy and keeps sticky
// overflow/underflow flags.
module bus_fifo_buffer #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] in,
   input  logic             pop,
   input  logic             enable,
   input  logic             clear_err,
   output wire  [WIDTH-1:0] out,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d, underflow_q, underflow_d;
   logic             push_ok, pop_ok;

   // Status is decoded from the registered count, so it lags the causing edge by one cycle.
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // A full FIFO can still take a push when the head is retired on the same edge.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop);

   // The bus is driven only from registered state; an empty FIFO never drives it.
   assign out = (enable && !empty) ? mem_q[rp_q] : {WIDTH{1'bz}};

   // Next-state for pointers, occupancy and sticky error flags.
   always_comb begin
      wp_d        = wp_q;
      rp_d        = rp_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (push_ok) wp_d = (wp_q == LAST) ? '0 : wp_q + 1'b1;
      if (pop_ok)  rp_d = (rp_q == LAST) ? '0 : rp_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // A new error in the same cycle as clear_err must win, so clear first.
      if (clear_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (push && full && !pop) overflow_d  = 1'b1;
      if (pop && empty)         underflow_d = 1'b1;
   end

   // Control state with asynchronous reset; reset discards every stored entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wp_q        <= '0;
         rp_q        <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array carries no reset; only written slots are ever driven onto the bus.
   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wp_q] <= in;
   end

endmodule

// File: tb/tb_bus_fifo_buffer.sv
// tb_bus_fifo_buffer: directed bench for bus_fifo_buffer at DEPTH=4 and DEPTH=3.
module tb_bus_fifo_buffer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       push = 1'b0, pop = 1'b0, enable = 1'b0, clear_err = 1'b0;
   logic [3:0] in = 4'h0;
   wire  [3:0] out4, out3;
   logic       full4, empty4, ovf4, unf4;
   logic       full3, empty3, ovf3, unf3;
   logic [2:0] count4;
   logic [1:0] count3;
   logic [3:0] zz;
   int         total = 0;
   int         bad = 0;

   bus_fifo_buffer #(.WIDTH(4), .DEPTH(4)) u4 (
      .clock(clock), .reset(reset), .push(push), .in(in), .pop(pop),
      .enable(enable), .clear_err(clear_err), .out(out4), .full(full4),
      .empty(empty4), .count(count4), .overflow(ovf4), .underflow(unf4));

   bus_fifo_buffer #(.WIDTH(4), .DEPTH(3)) u3 (
      .clock(clock), .reset(reset), .push(push), .in(in), .pop(pop),
      .enable(enable), .clear_err(clear_err), .out(out3), .full(full3),
      .empty(empty3), .count(count3), .overflow(ovf3), .underflow(unf3));

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cyc();
      enable = 1'b1;
      pop = 1'b1;
      cyc();
      pop = 1'b0;
      push = 1'b1; in = 4'h5;
      cyc();
      push = 1'b0;
      total++; if (out4 !== 4'h5) begin bad++; $display("FAIL rst_pre_out: got %h want 5", out4); end
      total++; if (unf4 !== 1'b1) begin bad++; $display("FAIL rst_pre_unf: got %b want 1", unf4); end
      #2 reset = 1'b1;
      #1;
      total++; if (out4 !== zz) begin bad++; $display("FAIL rst_out: got %h want z", out4); end
      total++; if (empty4 !== 1'b1 || full4 !== 1'b0) begin bad++; $display("FAIL rst_flags: got e=%b f=%b want e=1 f=0", empty4, full4); end
      total++; if (count4 !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count4); end
      total++; if (ovf4 !== 1'b0 || unf4 !== 1'b0) begin bad++; $display("FAIL rst_err: got o=%b u=%b want 0 0", ovf4, unf4); end
      cyc();
      reset = 1'b0;
      cyc();
   endtask

   task automatic fill4();
      logic [3:0] v [4];
      v = '{4'hA, 4'h3, 4'hF, 4'h6};
      push = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in = v[i];
         cyc();
         total++; if (out4 !== 4'hA) begin bad++; $display("FAIL fill_head%0d: got %h want a", i, out4); end
      end
      push = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [3:0] exp [4];
      exp = '{4'h3, 4'hF, 4'h6, 4'h0};
      enable = 1'b1;
      fill4();
      total++; if (full4 !== 1'b1 || count4 !== 3'd4) begin bad++; $display("FAIL fill_full: got f=%b c=%0d want 1 4", full4, count4); end
      pop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (i < 3) begin
            total++; if (out4 !== exp[i]) begin bad++; $display("FAIL drain%0d: got %h want %h", i, out4, exp[i]); end
         end else begin
            total++; if (out4 !== zz) begin bad++; $display("FAIL drain_z: got %h want z", out4); end
         end
      end
      pop = 1'b0;
      total++; if (empty4 !== 1'b1 || count4 !== 3'd0) begin bad++; $display("FAIL drain_empty: got e=%b c=%0d want 1 0", empty4, count4); end
   endtask

   task automatic test_overflow();
      logic [3:0] exp [4];
      exp = '{4'h3, 4'hF, 4'h6, 4'h7};
      fill4();
      push = 1'b1; in = 4'h1;
      cyc();
      push = 1'b0;
      total++; if (count4 !== 3'd4 || ovf4 !== 1'b1) begin bad++; $display("FAIL ovf_set: got c=%0d o=%b want 4 1", count4, ovf4); end
      total++; if (out4 !== 4'hA) begin bad++; $display("FAIL ovf_head: got %h want a", out4); end
      clear_err = 1'b1;
      cyc();
      clear_err = 1'b0;
      total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf4); end
      // full with push and pop: slot reused, no overflow
      push = 1'b1; pop = 1'b1; in = 4'h7;
      cyc();
      push = 1'b0;
      total++; if (count4 !== 3'd4 || ovf4 !== 1'b0) begin bad++; $display("FAIL full_pp: got c=%0d o=%b want 4 0", count4, ovf4); end
      for (int i = 0; i < 4; i++) begin
         total++; if (out4 !== exp[i]) begin bad++; $display("FAIL ovf_drain%0d: got %h want %h", i, out4, exp[i]); end
         cyc();
      end
      pop = 1'b0;
      total++; if (empty4 !== 1'b1 || out4 !== zz) begin bad++; $display("FAIL ovf_empty: got e=%b out=%h want 1 z", empty4, out4); end
   endtask

   task automatic test_underflow();
      push = 1'b1; pop = 1'b1; in = 4'h9;
      #1;
      total++; if (out4 !== zz) begin bad++; $display("FAIL no_bypass: got %h want z", out4); end
      cyc();
      push = 1'b0;
      total++; if (count4 !== 3'd1 || out4 !== 4'h9) begin bad++; $display("FAIL unf_push: got c=%0d out=%h want 1 9", count4, out4); end
      total++; if (unf4 !== 1'b1) begin bad++; $display("FAIL unf_set: got %b want 1", unf4); end
      cyc();
      pop = 1'b1; clear_err = 1'b1;
      cyc();
      total++; if (unf4 !== 1'b1 || count4 !== 3'd0) begin bad++; $display("FAIL unf_setwins: got u=%b c=%0d want 1 0", unf4, count4); end
      pop = 1'b0;
      cyc();
      clear_err = 1'b0;
      total++; if (unf4 !== 1'b0) begin bad++; $display("FAIL unf_clear: got %b want 0", unf4); end
   endtask

   task automatic test_wrap();
      logic [3:0] exp;
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      cyc();
      enable = 1'b1;
      push = 1'b1;
      in = 4'hC; cyc();
      in = 4'hD; cyc();
      pop = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in = 4'(k);
         cyc();
         exp = (k == 0) ? 4'hD : 4'(k - 1);
         total++; if (out4 !== exp || count4 !== 3'd2) begin bad++; $display("FAIL wrap4_%0d: got %h c=%0d want %h 2", k, out4, count4, exp); end
         total++; if (out3 !== exp || count3 !== 2'd2) begin bad++; $display("FAIL wrap3_%0d: got %h c=%0d want %h 2", k, out3, count3, exp); end
      end
      push = 1'b0; pop = 1'b0;
      total++; if (ovf4 | unf4 | ovf3 | unf3) begin bad++; $display("FAIL wrap_flags: got %b%b%b%b want 0000", ovf4, unf4, ovf3, unf3); end
   endtask

   task automatic test_enable();
      enable = 1'b1;
      cyc();
      total++; if (out4 !== 4'h8 || out3 !== 4'h8) begin bad++; $display("FAIL en1: got %h %h want 8", out4, out3); end
      enable = 1'b0;
      cyc();
      total++; if (out4 !== zz || out3 !== zz) begin bad++; $display("FAIL en0: got %h %h want z", out4, out3); end
      enable = 1'b1;
      cyc();
      total++; if (out4 !== 4'h8 || count4 !== 3'd2 || count3 !== 2'd2) begin bad++; $display("FAIL en1b: got %h c=%0d want 8 2", out4, count4); end
      pop = 1'b1;
      cyc();
      total++; if (out4 !== 4'h9 || out3 !== 4'h9) begin bad++; $display("FAIL tail: got %h %h want 9", out4, out3); end
      cyc();
      pop = 1'b0;
      total++; if (empty3 !== 1'b1 || out3 !== zz || full3 !== 1'b0) begin bad++; $display("FAIL d3_empty: got e=%b out=%h want 1 z", empty3, out3); end
   endtask

   initial begin
      zz = 4'bzzzz;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_wrap();
      test_enable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/bus_fifo_buffer.md
Name: bus_fifo_buffer

Overview:
- Parametrised successor to the team's 4-bit tri-state bus buffer.
- Captures nibbles from a producer into a DEPTH-entry FIFO and drives the oldest entry onto the shared tri-state data bus only while enabled and non-empty.
- Decouples ALU/accumulator results from bus arbitration in the Nibbler datapath.
- Reports occupancy, and raises sticky overflow/underflow error flags.

Parameters:
- WIDTH, 4, data width in bits (≥1).
- DEPTH, 4, number of FIFO entries (≥2; need not be a power of two).
- CW, $clog2(DEPTH+1), width of the count output (derived; do not override).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write in into the FIFO this cycle.
- in  input  WIDTH  write data.
- pop  input  1  retire the head entry this cycle.
- enable  input  1  bus drive enable.
- clear_err  input  1  synchronous clear of the sticky error flags.
- out  output  WIDTH  tri-state bus output.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  CW  number of stored entries.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high, named reset; clock port is named clock.
- Reset asserted, immediately and without waiting for a clock edge:
  - write and read pointers = 0, count = 0, empty = 1, full = 0;
  - overflow = 0, underflow = 0;
  - out = all Z.
  - Storage array contents are don't-care. Reset mid-operation discards all entries.
- Storage: DEPTH×WIDTH register array, write pointer wp, read pointer rp. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by truncation.
- Push accepted (push && !full): mem[wp] <= in; wp advances.
- Pop accepted (pop && !empty): rp advances. Popped data is not returned separately; it was visible on out before the edge.
- Simultaneous push and pop:
  - not full and not empty: both accepted, count unchanged;
  - full: pop accepted, and push also accepted (the freed slot is reused in the same edge); count stays DEPTH, no overflow;
  - empty: push accepted, pop rejected, underflow set; count becomes 1. There is no bypass: data never appears on out in the cycle it is pushed.
- Rejected operations:
  - push && full && !pop: nothing written, overflow <= 1;
  - pop && empty: pointers unchanged, underflow <= 1.
- count updates: +1, -1 or unchanged per accepted operations; never exceeds DEPTH or goes below 0. full and empty are decoded from the registered count, so they are valid the cycle after the causing edge.
- Error flags:
  - overflow and underflow stay 1 until clear_err or reset.
  - If clear_err and a new error condition occur in the same cycle, the flag is set: set wins over clear.
- Bus drive, purely combinational from registered state:
  - out = mem[rp] when enable && !empty, else all Z;
  - enable alone, when empty, never drives the bus.
  - Latency: an entry pushed at edge N is drivable from just after edge N.
- No X may reach out while driven. mem[rp] is always a written entry whenever empty = 0.

Test Plan:
- Reset / idle: assert reset mid-cycle with enable=1 → out=ZZZZ, empty=1, count=0, flags 0, with no clock edge required.
- Fill and drain: push 4'hA, 4'h3, 4'hF, 4'h6 with enable=1 → after the 4th edge full=1, count=4, out=4'hA. Four pops → out shows 3, F, 6, then ZZZZ; empty=1.
- Overflow: with the FIFO full, push 4'h1 alone → count stays 4, overflow=1, contents unchanged. clear_err one cycle → overflow=0.
- Underflow with simultaneous push: with the FIFO empty, push 4'h9 and pop together → count=1, out=9 (enable=1), underflow=1. Pulse clear_err together with a pop on empty → underflow remains 1.
- Wrap-around: 10 cycles of simultaneous push/pop at count=2 with data 0..9 → out sequence strictly in order, count stays 2, no flags set. Repeat with DEPTH=3 to check non-power-of-two pointer wrap.
- Enable gating: with count=2, toggle enable 1/0/1 → out alternates head value/ZZZZ/head value; count unchanged.
